// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between two requesters (fetch, load/store), the arbiter and one memory slave.
// master: the environment (requesters and memory); slave: the arbiter serving them.
interface mem_bus_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              m0_req_valid;
  logic              m0_req_ready;
  logic [ADDR_W-1:0] m0_addr;
  logic              m0_rsp_valid;
  logic [DATA_W-1:0] m0_rsp_data;

  logic              m1_req_valid;
  logic              m1_req_ready;
  logic [ADDR_W-1:0] m1_addr;
  logic              m1_we;
  logic [DATA_W-1:0] m1_wdata;
  logic [STRB_W-1:0] m1_wstrb;
  logic              m1_rsp_valid;
  logic [DATA_W-1:0] m1_rsp_data;

  logic              s_req_valid;
  logic              s_req_ready;
  logic [ADDR_W-1:0] s_addr;
  logic              s_we;
  logic [DATA_W-1:0] s_wdata;
  logic [STRB_W-1:0] s_wstrb;
  logic              s_rsp_valid;
  logic [DATA_W-1:0] s_rsp_data;

  logic              busy_o;
  logic              owner_o;

  modport master (
    output m0_req_valid, m0_addr,
    input  m0_req_ready, m0_rsp_valid, m0_rsp_data,
    output m1_req_valid, m1_addr, m1_we, m1_wdata, m1_wstrb,
    input  m1_req_ready, m1_rsp_valid, m1_rsp_data,
    input  s_req_valid, s_addr, s_we, s_wdata, s_wstrb,
    output s_req_ready, s_rsp_valid, s_rsp_data,
    input  busy_o, owner_o
  );

  modport slave (
    input  m0_req_valid, m0_addr,
    output m0_req_ready, m0_rsp_valid, m0_rsp_data,
    input  m1_req_valid, m1_addr, m1_we, m1_wdata, m1_wstrb,
    output m1_req_ready, m1_rsp_valid, m1_rsp_data,
    output s_req_valid, s_addr, s_we, s_wdata, s_wstrb,
    input  s_req_ready, s_rsp_valid, s_rsp_data,
    output busy_o, owner_o
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master, one-slave memory arbiter with a single outstanding transaction.
// Define ARB_ROUND_ROBIN_EN to alternate grants on contention; otherwise M1 has fixed priority.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input logic               clk,
  input logic               rst,
  mem_bus_arbiter_if.slave  bus
);
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {StIdle, StReq, StRsp} state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic              rst_hold_q;
  logic              grant_m1;
  logic              accept;

`ifdef ARB_ROUND_ROBIN_EN
  logic prefer_m1_q;

  assign grant_m1 = bus.m1_req_valid & (~bus.m0_req_valid | prefer_m1_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      prefer_m1_q <= 1'b1;
    end else if (accept) begin
      prefer_m1_q <= ~grant_m1;
    end
  end
`else
  assign grant_m1 = bus.m1_req_valid;
`endif

  // No grants while in reset or during the first cycle after it.
  assign accept = (state_q == StIdle) & ~rst & ~rst_hold_q &
                  (bus.m0_req_valid | bus.m1_req_valid);

  always_ff @(posedge clk) begin
    rst_hold_q <= rst;
    if (rst) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StReq;
          owner_d = grant_m1;
          if (grant_m1) begin
            addr_d  = bus.m1_addr;
            we_d    = bus.m1_we;
            wdata_d = bus.m1_wdata;
            wstrb_d = bus.m1_wstrb;
          end else begin
            addr_d  = bus.m0_addr;
            we_d    = 1'b0;
            wdata_d = '0;
            wstrb_d = '0;
          end
        end
      end
      StReq: begin
        if (bus.s_req_ready) state_d = StRsp;
      end
      StRsp: begin
        if (bus.s_rsp_valid) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.m0_req_ready = accept & ~grant_m1;
  assign bus.m1_req_ready = accept & grant_m1;

  assign bus.s_req_valid = (state_q == StReq) & ~rst;
  assign bus.s_addr      = addr_q;
  assign bus.s_we        = we_q;
  assign bus.s_wdata     = wdata_q;
  assign bus.s_wstrb     = wstrb_q;

  // Responses are forwarded only to the owner and only while one is expected.
  assign bus.m0_rsp_valid = (state_q == StRsp) & ~rst & ~owner_q & bus.s_rsp_valid;
  assign bus.m1_rsp_valid = (state_q == StRsp) & ~rst & owner_q & bus.s_rsp_valid;
  assign bus.m0_rsp_data  = bus.s_rsp_data;
  assign bus.m1_rsp_data  = bus.s_rsp_data;

  assign bus.busy_o  = (state_q != StIdle) & ~rst;
  assign bus.owner_o = owner_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: expected responses are queued at grant time and
// popped when a master response appears.
module tb_mem_bus_arbiter;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    bit          m1;
    logic [31:0] data;
  } sb_item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  bit   pref_m1 = 1'b1;
  sb_item_t sbq[$];

  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration: returns the expected winner and advances the model pointer.
  function automatic bit model_winner(input bit v0, input bit v1);
    bit w;
    if (v0 && v1) w = RR ? pref_m1 : 1'b1;
    else          w = v1;
    pref_m1 = ~w;
    return w;
  endfunction

  // Runs one transaction whose request(s) are already driven; checks grant, slave-side
  // fields through 'stall' backpressure cycles, then the response routing.
  task automatic txn(input string tag, input logic [31:0] a, input bit we, input logic [31:0] wd,
                     input logic [3:0] ws, input logic [31:0] rdata, input int stall,
                     input bit keep);
    sb_item_t it;
    sb_item_t got;
    bit       w;
    w = model_winner(bus.m0_req_valid, bus.m1_req_valid);
    @(negedge clk);
    chk({tag, "_grant"}, {62'd0, bus.m1_req_ready, bus.m0_req_ready}, w ? 64'd2 : 64'd1);
    it.m1 = w;
    it.data = rdata;
    sbq.push_back(it);
    @(posedge clk); #1;
    if (!keep) begin
      bus.m0_req_valid = 1'b0;
      bus.m1_req_valid = 1'b0;
    end
    bus.s_req_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({tag, "_stall_fields"}, {bus.s_req_valid, bus.s_we, ws == 4'h0 ? 4'h0 : bus.s_wstrb,
          bus.s_addr, 22'd0}, {1'b1, we, ws, a, 22'd0});
      if (we) chk({tag, "_stall_wdata"}, {32'd0, bus.s_wdata}, {32'd0, wd});
      chk({tag, "_stall_norsp"}, {62'd0, bus.m1_rsp_valid, bus.m0_rsp_valid}, 64'd0);
      @(posedge clk); #1;
    end
    bus.s_req_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_req"}, {bus.s_req_valid, bus.s_we, bus.s_wstrb, bus.s_addr, bus.busy_o,
        bus.owner_o, bus.m0_req_ready, bus.m1_req_ready, 18'd0},
        {1'b1, we, ws, a, 1'b1, w, 2'b00, 18'd0});
    @(posedge clk); #1;
    bus.s_req_ready = 1'b0;
    bus.s_rsp_valid = 1'b1;
    bus.s_rsp_data  = rdata;
    @(negedge clk);
    chk({tag, "_sreq_drop"}, {63'd0, bus.s_req_valid}, 64'd0);
    if (sbq.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      got = sbq.pop_front();
      chk({tag, "_rsp_route"}, {62'd0, bus.m1_rsp_valid, bus.m0_rsp_valid}, got.m1 ? 64'd2 : 64'd1);
      chk({tag, "_rsp_data"}, {32'd0, got.m1 ? bus.m1_rsp_data : bus.m0_rsp_data},
          {32'd0, got.data});
    end
    @(posedge clk); #1;
    bus.s_rsp_valid = 1'b0;
  endtask

  initial begin
    bus.m0_req_valid = 1'b0;
    bus.m0_addr      = '0;
    bus.m1_req_valid = 1'b1;
    bus.m1_addr      = 32'h0000_0040;
    bus.m1_we        = 1'b0;
    bus.m1_wdata     = '0;
    bus.m1_wstrb     = '0;
    bus.s_req_ready  = 1'b1;
    bus.s_rsp_valid  = 1'b1;
    bus.s_rsp_data   = 32'h1111_1111;

    // Reset with a pending request and stray slave activity: everything stays quiet.
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_outputs", {58'd0, bus.m0_req_ready, bus.m1_req_ready, bus.s_req_valid,
        bus.m0_rsp_valid, bus.m1_rsp_valid, bus.busy_o}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_quiet", {60'd0, bus.m1_req_ready, bus.busy_o, bus.m1_rsp_valid,
        bus.owner_o}, 64'd0);
    chk("post_rst_latched", {bus.s_addr, bus.s_wdata}, 64'd0);
    chk("post_rst_we_strb", {59'd0, bus.s_we, bus.s_wstrb}, 64'd0);
    bus.m1_req_valid = 1'b0;
    bus.s_rsp_valid  = 1'b0;
    @(posedge clk); #1;

    // Single fetch from M0, then idle at N+3.
    bus.m0_req_valid = 1'b1;
    bus.m0_addr      = 32'h0000_0100;
    txn("fetch", 32'h100, 1'b0, 32'h0, 4'h0, 32'hDEAD_BEEF, 0, 1'b0);
    @(negedge clk);
    chk("fetch_idle", {63'd0, bus.busy_o}, 64'd0);
    @(posedge clk); #1;

    // Contention: both masters valid for four back-to-back transactions.
    bus.m0_req_valid = 1'b1;
    bus.m0_addr      = 32'h0000_0400;
    bus.m1_req_valid = 1'b1;
    bus.m1_addr      = 32'h0000_0800;
    bus.m1_we        = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bit nxt;
      nxt = (bus.m0_req_valid && bus.m1_req_valid) ? (RR ? pref_m1 : 1'b1) : bus.m1_req_valid;
      txn("contend", nxt ? 32'h800 : 32'h400, 1'b0, 32'h0, 4'h0, 32'hA000_0000 + k, 0, 1'b1);
    end
    bus.m0_req_valid = 1'b0;
    bus.m1_req_valid = 1'b0;

    // M1 write held off by five cycles of slave backpressure.
    bus.m1_req_valid = 1'b1;
    bus.m1_addr      = 32'h0000_2000;
    bus.m1_we        = 1'b1;
    bus.m1_wdata     = 32'h1234_5678;
    bus.m1_wstrb     = 4'hF;
    txn("bp_write", 32'h2000, 1'b1, 32'h1234_5678, 4'hF, 32'h0000_0ACC, 5, 1'b0);
    bus.m1_we = 1'b0;

    // Stray response while idle.
    bus.s_rsp_valid = 1'b1;
    bus.s_rsp_data  = 32'h5555_5555;
    @(negedge clk);
    chk("stray_rsp", {61'd0, bus.m0_rsp_valid, bus.m1_rsp_valid, bus.busy_o}, 64'd0);
    @(posedge clk); #1;
    bus.s_rsp_valid = 1'b0;
    @(negedge clk);
    chk("stray_stay_idle", {62'd0, bus.busy_o, bus.s_req_valid}, 64'd0);
    @(posedge clk); #1;

    // Reset during RSP, stale ack afterwards, then a normal transaction.
    bus.m0_req_valid = 1'b1;
    bus.m0_addr      = 32'h0000_0300;
    @(negedge clk);
    chk("midrst_grant", {63'd0, bus.m0_req_ready}, 64'd1);
    @(posedge clk); #1;
    bus.s_req_ready = 1'b1;
    @(posedge clk); #1;
    bus.s_req_ready = 1'b0;
    @(negedge clk);
    chk("midrst_in_rsp", {63'd0, bus.busy_o}, 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    pref_m1 = 1'b1;
    bus.s_rsp_valid = 1'b1;
    bus.s_rsp_data  = 32'h0000_0BAD;
    @(negedge clk);
    chk("midrst_stale", {60'd0, bus.m0_rsp_valid, bus.m1_rsp_valid, bus.busy_o,
        bus.m0_req_ready}, 64'd0);
    @(posedge clk); #1;
    bus.s_rsp_valid = 1'b0;
    txn("after_rst", 32'h300, 1'b0, 32'h0, 4'h0, 32'hCAFE_0001, 1, 1'b0);

    chk("sb_drained", {32'd0, sbq.size()}, 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
